// File: rtl/ras.sv
// Return address stack: circular target buffer with top index and occupancy count.
// The pointer/count pair is exported every cycle so the backend can checkpoint and restore it.
module ras #(
    parameter int unsigned RAS_DEPTH        = 8,
    parameter int unsigned RAS_TARGET_WIDTH = 12,
    localparam int unsigned LOG_RAS_DEPTH   = $clog2(RAS_DEPTH)
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        ctrl_valid,
    input  logic                        ctrl_push,
    input  logic                        ctrl_pop,
    input  logic [RAS_TARGET_WIDTH-1:0] ctrl_push_target,
    output logic                        pred_ret_valid,
    output logic [RAS_TARGET_WIDTH-1:0] pred_ret_target,
    output logic [LOG_RAS_DEPTH-1:0]    pred_ras_index,
    output logic [LOG_RAS_DEPTH:0]      pred_ras_count,
    input  logic                        restore_valid,
    input  logic [LOG_RAS_DEPTH-1:0]    restore_ras_index,
    input  logic [LOG_RAS_DEPTH:0]      restore_ras_count
);

    localparam logic [LOG_RAS_DEPTH:0]   DEPTH_C = (LOG_RAS_DEPTH+1)'(RAS_DEPTH);
    localparam logic [LOG_RAS_DEPTH-1:0] IDX_ONE = LOG_RAS_DEPTH'(1);
    localparam logic [LOG_RAS_DEPTH:0]   CNT_ONE = (LOG_RAS_DEPTH+1)'(1);

    logic [RAS_TARGET_WIDTH-1:0] entries [RAS_DEPTH];
    logic [LOG_RAS_DEPTH-1:0]    ptr, ptr_nxt, ptr_inc, ptr_dec, wr_idx;
    logic [LOG_RAS_DEPTH:0]      count, count_nxt;
    logic                        wr_en;
    logic                        empty, full;
    logic                        do_push, do_pop;

    assign ptr_inc = ptr + IDX_ONE;
    assign ptr_dec = ptr - IDX_ONE;
    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_push = ctrl_valid & ctrl_push;
    assign do_pop  = ctrl_valid & ctrl_pop;

    always_comb begin
        ptr_nxt   = ptr;
        count_nxt = count;
        wr_en     = 1'b0;
        wr_idx    = ptr;
        if (restore_valid) begin
            // Pointer-only recovery; stack contents are left as they are.
            ptr_nxt   = restore_ras_index;
            count_nxt = (restore_ras_count > DEPTH_C) ? DEPTH_C : restore_ras_count;
        end else if (do_push && (!do_pop || empty)) begin
            wr_en     = 1'b1;
            wr_idx    = ptr_inc;
            ptr_nxt   = ptr_inc;
            count_nxt = full ? count : count + CNT_ONE;
        end else if (do_push && do_pop) begin
            // Return followed by call: the new target replaces the current top in place.
            wr_en = 1'b1;
        end else if (do_pop && !empty) begin
            ptr_nxt   = ptr_dec;
            count_nxt = count - CNT_ONE;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ptr   <= '0;
            count <= '0;
        end else begin
            ptr   <= ptr_nxt;
            count <= count_nxt;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < int'(RAS_DEPTH); i++)
                entries[i] <= '0;
        end else if (wr_en) begin
            entries[wr_idx] <= ctrl_push_target;
        end
    end

    assign pred_ret_valid  = !empty;
    assign pred_ret_target = entries[ptr];
    assign pred_ras_index  = ptr;
    assign pred_ras_count  = count;

endmodule

// File: tb/tb_ras.sv
// Directed plus randomized bench for ras, checked against a modulo-arithmetic stack model.
module tb_ras;
    localparam int D = 8;
    localparam int W = 12;
    localparam int L = 3;

    logic         CLK = 1'b0;
    logic         nRST;
    logic         ctrl_valid, ctrl_push, ctrl_pop;
    logic [W-1:0] ctrl_push_target;
    logic         pred_ret_valid;
    logic [W-1:0] pred_ret_target;
    logic [L-1:0] pred_ras_index;
    logic [L:0]   pred_ras_count;
    logic         restore_valid;
    logic [L-1:0] restore_ras_index;
    logic [L:0]   restore_ras_count;

    ras #(.RAS_DEPTH(D), .RAS_TARGET_WIDTH(W)) dut (
        .CLK(CLK), .nRST(nRST),
        .ctrl_valid(ctrl_valid), .ctrl_push(ctrl_push), .ctrl_pop(ctrl_pop),
        .ctrl_push_target(ctrl_push_target),
        .pred_ret_valid(pred_ret_valid), .pred_ret_target(pred_ret_target),
        .pred_ras_index(pred_ras_index), .pred_ras_count(pred_ras_count),
        .restore_valid(restore_valid), .restore_ras_index(restore_ras_index),
        .restore_ras_count(restore_ras_count)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: stack as an array with integer top/occupancy, modulo indexing.
    int           m_ptr, m_cnt;
    logic [W-1:0] m_mem [D];
    int           ck_ptr, ck_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".valid"},  32'(pred_ret_valid),  32'(m_cnt != 0));
        check({tag, ".target"}, 32'(pred_ret_target), 32'(m_mem[m_ptr]));
        check({tag, ".index"},  32'(pred_ras_index),  32'(m_ptr));
        check({tag, ".count"},  32'(pred_ras_count),  32'(m_cnt));
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_cnt = 0;
        for (int i = 0; i < D; i++) m_mem[i] = '0;
    endtask

    task automatic model_apply(input logic v, pu, po, input logic [W-1:0] tgt,
                               input logic rv, input int ri, input int rc);
        if (rv) begin
            m_ptr = ri;
            m_cnt = (rc > D) ? D : rc;
        end else if (v && pu && (!po || m_cnt == 0)) begin
            m_ptr = (m_ptr + 1) % D;
            m_mem[m_ptr] = tgt;
            if (m_cnt < D) m_cnt++;
        end else if (v && pu && po) begin
            m_mem[m_ptr] = tgt;
        end else if (v && po && m_cnt > 0) begin
            m_ptr = (m_ptr + D - 1) % D;
            m_cnt--;
        end
    endtask

    task automatic drive_idle();
        ctrl_valid = 0; ctrl_push = 0; ctrl_pop = 0; ctrl_push_target = '0;
        restore_valid = 0; restore_ras_index = '0; restore_ras_count = '0;
    endtask

    // Entered at posedge+1: drive, check pre-update state, clock, update model.
    task automatic cyc(input logic v, pu, po, input logic [W-1:0] tgt,
                       input logic rv, input logic [L-1:0] ri, input logic [L:0] rc,
                       input string tag);
        ctrl_valid = v; ctrl_push = pu; ctrl_pop = po; ctrl_push_target = tgt;
        restore_valid = rv; restore_ras_index = ri; restore_ras_count = rc;
        #1 check_state(tag);
        @(posedge CLK);
        model_apply(v, pu, po, tgt, rv, int'(ri), int'(rc));
        #1 drive_idle();
    endtask

    task automatic push(input logic [W-1:0] t);    cyc(1, 1, 0, t,  0, '0, '0, "push"); endtask
    task automatic pop();                          cyc(1, 0, 1, '0, 0, '0, '0, "pop");  endtask
    task automatic pushpop(input logic [W-1:0] t); cyc(1, 1, 1, t,  0, '0, '0, "pp");   endtask
    task automatic idle();                         cyc(0, 0, 0, '0, 0, '0, '0, "idle"); endtask
    task automatic restore(input int i, input int c);
        cyc(0, 0, 0, '0, 1, L'(i), (L+1)'(c), "restore");
    endtask

    initial begin
        drive_idle();
        nRST = 0;
        model_reset();
        #12 nRST = 1;
        @(posedge CLK); #1;

        // Reset state
        check("rst.valid",  32'(pred_ret_valid),  32'h0);
        check("rst.target", 32'(pred_ret_target), 32'h0);
        check("rst.index",  32'(pred_ras_index),  32'h0);
        check("rst.count",  32'(pred_ras_count),  32'h0);
        idle();

        // LIFO order and pop on empty
        push(12'h111); push(12'h222); push(12'h333);
        check("lifo.top0", 32'(pred_ret_target), 32'h333); pop();
        check("lifo.top1", 32'(pred_ret_target), 32'h222); pop();
        check("lifo.top2", 32'(pred_ret_target), 32'h111); pop();
        check("lifo.empty_cnt", 32'(pred_ras_count), 32'h0);
        pop();
        check("lifo.pop_empty_idx", 32'(pred_ras_index), 32'h0);
        check("lifo.pop_empty_cnt", 32'(pred_ras_count), 32'h0);

        // Overflow wrap
        restore(0, 0);
        for (int i = 1; i <= 10; i++) push(W'(i));
        check("wrap.count", 32'(pred_ras_count), 32'd8);
        check("wrap.index", 32'(pred_ras_index), 32'd2);
        for (int i = 10; i >= 3; i--) begin
            check("wrap.pop_tgt", 32'(pred_ret_target), 32'(i));
            pop();
        end
        check("wrap.final_cnt", 32'(pred_ras_count), 32'd0);

        // Push+pop replace, then on empty stack
        restore(0, 0);
        push(12'h0AA); push(12'h0BB);
        pushpop(12'h0CC);
        check("pp.top", 32'(pred_ret_target), 32'h0CC);
        check("pp.idx", 32'(pred_ras_index),  32'd2);
        check("pp.cnt", 32'(pred_ras_count),  32'd2);
        pop(); pop();
        pushpop(12'h0DD);
        check("pp_empty.cnt", 32'(pred_ras_count),  32'd1);
        check("pp_empty.top", 32'(pred_ret_target), 32'h0DD);

        // Checkpoint restore after overwrite
        restore(0, 0);
        push(12'h100); push(12'h200);
        pop(); pop(); push(12'h300);
        restore(2, 2);
        check("rest.idx", 32'(pred_ras_index),  32'd2);
        check("rest.cnt", 32'(pred_ras_count),  32'd2);
        check("rest.top", 32'(pred_ret_target), 32'h200);

        // Restore wins over push; oversize count clamps
        cyc(1, 1, 0, 12'hEEE, 1, 3'd5, 4'd15, "rest_prio");
        check("prio.idx", 32'(pred_ras_index), 32'd5);
        check("prio.cnt", 32'(pred_ras_count), 32'd8);
        restore(6, 3);
        check("prio.nowrite", 32'(pred_ret_target), 32'(m_mem[6]));

        // Randomized traffic, occasionally restoring a saved checkpoint
        ck_ptr = m_ptr; ck_cnt = m_cnt;
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if ($urandom_range(0, 7) == 0) begin ck_ptr = m_ptr; ck_cnt = m_cnt; end
            if (r == 0)      restore(ck_ptr, ck_cnt);
            else if (r == 1) restore(int'($urandom_range(0, D-1)), int'($urandom_range(0, 15)));
            else cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                     W'($urandom), 0, '0, '0, "rand");
        end

        // Async reset mid-operation, with a pending push
        push(12'h5A5); push(12'hA5A);
        ctrl_valid = 1; ctrl_push = 1; ctrl_push_target = 12'h777;
        #2 nRST = 0;
        #1;
        model_reset();
        check("arst.valid",  32'(pred_ret_valid),  32'h0);
        check("arst.target", 32'(pred_ret_target), 32'h0);
        check("arst.index",  32'(pred_ras_index),  32'h0);
        check("arst.count",  32'(pred_ras_count),  32'h0);
        @(posedge CLK); #3;
        nRST = 1;
        drive_idle();
        @(posedge CLK); #1;
        idle();
        push(12'h042);
        check("post_rst.top", 32'(pred_ret_target), 32'h042);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
